// File: rtl/deser8_msb_align_pkg.sv
// Shared constants and FSM state encodings for the 8-bit MSB-first deserializer.
package deser8_msb_align_pkg;

   localparam int unsigned WORD_W = 8;
   localparam int unsigned OFF_W  = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WAIT_W = 3;

   localparam logic [WORD_W-1:0] ALIGN_PATTERN_DEF = 8'hBC;

   typedef logic [1:0] state_t;
   localparam state_t ST_SEARCH = 2'd0;
   localparam state_t ST_CHECK  = 2'd1;
   localparam state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/deser8_msb_align_deser.sv
// deser_block_msb: clk320 shift register with toggle-synchronised word load into hold320.
module deser_block_msb
   import deser8_msb_align_pkg::*;
(
   input  logic              clk40,
   input  logic              rstn,
   input  logic              clk320,
   input  logic              sin,
   output logic [WORD_W-1:0] hold320
);

   logic              tg;
   logic [2:0]        dl;
   logic [WORD_W-1:0] sr;
   logic              load;

   // Word-rate toggle; each edge of it marks one word boundary in the bit domain.
   always_ff @(posedge clk40) begin
      if (!rstn) tg <= 1'b0;
      else       tg <= ~tg;
   end

   assign load = dl[2] ^ dl[1];

   // Bit-clock side is deliberately unreset; it refills within one word.
   always_ff @(posedge clk320) begin
      sr <= {sr[WORD_W-2:0], sin};
      dl <= {dl[1:0], tg};
      if (load) hold320 <= sr;
   end

endmodule

// File: rtl/deser8_msb_align.sv
// 8-bit MSB-first deserializer with bit-slip word alignment.
// Define DESER_ALIGN_EN to build the alignment FSM; otherwise offset is fixed at 0.
module deser8_msb_align
   import deser8_msb_align_pkg::*;
#(
   parameter logic [WORD_W-1:0] ALIGN_PATTERN = ALIGN_PATTERN_DEF,
   parameter int unsigned       LOCK_COUNT    = 4,
   parameter int unsigned       SLIP_WAIT     = 2
)(
   input  logic              clk40,
   input  logic              rstn,
   input  logic              clk320,
   input  logic              sin,
   input  logic              align_start,
   output logic [WORD_W-1:0] dout,
   output logic              locked,
   output logic [OFF_W-1:0]  offset
);

   logic [WORD_W-1:0] hold320;
   logic [WORD_W-1:0] cur;

   deser_block_msb u_deser (
      .clk40   (clk40),
      .rstn    (rstn),
      .clk320  (clk320),
      .sin     (sin),
      .hold320 (hold320)
   );

`ifdef DESER_ALIGN_EN

   localparam logic [CNT_W-1:0]  LOCK_N = CNT_W'(LOCK_COUNT);
   localparam logic [WAIT_W-1:0] WAIT_N = WAIT_W'(SLIP_WAIT);

   logic [WORD_W-1:0]   prev;
   logic [2*WORD_W-1:0] win_c;
   logic [WORD_W-1:0]   aligned_c;
   logic                hit_c;

   state_t              state,     state_nx;
   logic [CNT_W-1:0]    match_cnt, match_cnt_nx;
   logic [WAIT_W-1:0]   wait_cnt,  wait_cnt_nx;
   logic [OFF_W-1:0]    offset_nx;
   logic                locked_nx;

   // Offset k takes the k most recent bits of prev ahead of cur.
   assign win_c     = {prev, cur};
   assign aligned_c = win_c[offset +: WORD_W];
   assign hit_c     = (aligned_c == ALIGN_PATTERN);

   always_ff @(posedge clk40) begin
      if (!rstn) begin
         cur  <= '0;
         prev <= '0;
         dout <= '0;
      end else begin
         cur  <= hold320;
         prev <= cur;
         dout <= aligned_c;
      end
   end

   always_ff @(posedge clk40) begin
      if (!rstn) begin
         state     <= ST_SEARCH;
         match_cnt <= '0;
         wait_cnt  <= WAIT_N;
         offset    <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nx;
         match_cnt <= match_cnt_nx;
         wait_cnt  <= wait_cnt_nx;
         offset    <= offset_nx;
         locked    <= locked_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      match_cnt_nx = match_cnt;
      wait_cnt_nx  = wait_cnt;
      offset_nx    = offset;
      locked_nx    = 1'b0;

      case (state)
         ST_SEARCH: begin
            if (wait_cnt != '0) begin
               wait_cnt_nx = wait_cnt - 1'b1;
            end else if (hit_c) begin
               match_cnt_nx = CNT_W'(1);
               state_nx     = (match_cnt_nx >= LOCK_N) ? ST_LOCKED : ST_CHECK;
            end else begin
               offset_nx   = offset + 1'b1;
               wait_cnt_nx = WAIT_N;
            end
         end
         ST_CHECK: begin
            if (hit_c) begin
               if (match_cnt != '1) match_cnt_nx = match_cnt + 1'b1;
               if (match_cnt_nx >= LOCK_N) state_nx = ST_LOCKED;
            end else begin
               match_cnt_nx = '0;
               offset_nx    = offset + 1'b1;
               wait_cnt_nx  = WAIT_N;
               state_nx     = ST_SEARCH;
            end
         end
         ST_LOCKED: begin
            state_nx = ST_LOCKED;
         end
         default: begin
            state_nx = ST_SEARCH;
         end
      endcase

      // Restart keeps the offset so a correctly aligned link relocks in place.
      if (align_start) begin
         state_nx     = ST_SEARCH;
         match_cnt_nx = '0;
         wait_cnt_nx  = WAIT_N;
         offset_nx    = offset;
      end

      locked_nx = (state_nx == ST_LOCKED);
   end

`else

   logic unused_cfg;

   assign unused_cfg = align_start ^ (^ALIGN_PATTERN) ^ (LOCK_COUNT == 0) ^ (SLIP_WAIT == 0);
   assign offset     = '0;

   always_ff @(posedge clk40) begin
      if (!rstn) begin
         cur    <= '0;
         dout   <= '0;
         locked <= 1'b0;
      end else begin
         cur    <= hold320;
         dout   <= cur;
         locked <= 1'b1;
      end
   end

`endif

endmodule

// File: tb/tb_deser8_msb_align.sv
// Loopback bench: a bit-accurate MSB-first serializer model feeds the deserializer; scoreboarded words.
module tb_deser8_msb_align;

   localparam logic [7:0] PAT     = 8'hBC;
   localparam int         LCNT    = 4;
   localparam int         SWAIT   = 2;
   localparam int         NWORDS  = 4096;

   logic       clk40 = 1'b0;
   logic       clk320 = 1'b0;
   logic       rstn = 1'b0;
   logic       sin = 1'b0;
   logic       align_start = 1'b0;
   logic [7:0] dout;
   logic       locked;
   logic [2:0] offset;

   logic [7:0] txw [0:NWORDS-1];
   int         dly = 0;
   int         nneg = 0;
   int         cyc = -1;
   int         base = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;
   exp_t sb_q[$];

   deser8_msb_align #(
      .ALIGN_PATTERN (PAT),
      .LOCK_COUNT    (LCNT),
      .SLIP_WAIT     (SWAIT)
   ) dut (
      .clk40       (clk40),
      .rstn        (rstn),
      .clk320      (clk320),
      .sin         (sin),
      .align_start (align_start),
      .dout        (dout),
      .locked      (locked),
      .offset      (offset)
   );

   // clk320 posedges at 2+4i, clk40 posedges at 18+32m: every clk40 edge is a clk320 edge
   initial forever #2 clk320 = ~clk320;
   initial begin
      #2;
      forever #16 clk40 = ~clk40;
   end

   always @(posedge clk40) cyc <= cyc + 1;

   // Word k is sent MSB first on the clk320 negedges starting at 28+32k, shifted by dly bits
   always @(negedge clk320) begin
      int         s;
      logic [7:0] w;
      nneg = nneg + 1;
      s = nneg - 7 - dly;
      if (s < 0 || s / 8 >= NWORDS) begin
         sin = 1'b0;
      end else begin
         w   = txw[s / 8];
         sin = w[7 - (s % 8)];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard monitor: each queued word is compared on the cycle it is due on dout
   always @(negedge clk40) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         exp_t e;
         e = sb_q.pop_front();
         if (e.due == cyc) check_val("dout_sb", 32'(dout), 32'(e.data));
         else              check_val("dout_sb_missed", 32'(e.due), 32'(cyc));
      end
   end

   task automatic send_word(input int k, input logic [7:0] w, input int lat);
      txw[k] = w;
      sb_q.push_back('{data: w, due: k + lat});
   endtask

   task automatic drain(input string tag);
      int n;
      logic lost;
      n = 0;
      lost = 1'b0;
      while (sb_q.size() > 0 && n < 24) begin
         @(negedge clk40);
         if (locked !== 1'b1) lost = 1'b1;
         n++;
      end
      check_val({tag, "_locked_held"}, 32'(lost), 32'd0);
      check_val({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic do_reset(input int ncyc, input int d);
      @(negedge clk40);
      rstn = 1'b0;
      dly  = d;
      repeat (ncyc) @(negedge clk40);
      rstn = 1'b1;
      base = cyc;
   endtask

   task automatic wait_lock(input string tag, input int budget);
      int n;
      n = 0;
      while (locked !== 1'b1 && n < budget) begin
         @(negedge clk40);
         n++;
      end
      check_val(tag, 32'(locked), 32'd1);
   endtask

   initial begin
      int k0;
      logic slipped;
      for (int i = 0; i < NWORDS; i++) txw[i] = PAT;

      repeat (3) @(negedge clk40);
      check_val("rst_dout", 32'(dout), 32'd0);
      check_val("rst_locked", 32'(locked), 32'd0);
      check_val("rst_offset", 32'(offset), 32'd0);
      rstn = 1'b1;
      base = cyc;

`ifdef DESER_ALIGN_EN
      // Delay 0: lock in place at offset 0
      wait_lock("lock_d0", 2 + LCNT + SWAIT);
      check_val("offset_d0", 32'(offset), 32'd0);
      @(negedge clk40);
      check_val("dout_d0", 32'(dout), 32'(PAT));

      // Payload after lock must pass through unchanged
      k0 = cyc + 2;
      send_word(k0,     8'h00, 3);
      send_word(k0 + 1, 8'hFF, 3);
      send_word(k0 + 2, 8'hA5, 3);
      send_word(k0 + 3, 8'h5A, 3);
      drain("payload_d0");

      // One-cycle reset while locked
      @(negedge clk40);
      rstn = 1'b0;
      @(negedge clk40);
      check_val("midrst_locked", 32'(locked), 32'd0);
      check_val("midrst_offset", 32'(offset), 32'd0);
      check_val("midrst_dout", 32'(dout), 32'd0);
      rstn = 1'b1;
      base = cyc;
      wait_lock("relock_after_rst", 2 + LCNT + SWAIT);

      // Corrupted word seen in CHECK forces a slip, then a full lap back to offset 0
      do_reset(2, 0);
      txw[base + 1] = 8'hBD;
      repeat (4) @(negedge clk40);
      check_val("bd_slip_offset", 32'(offset), 32'd1);
      check_val("bd_slip_locked", 32'(locked), 32'd0);
      wait_lock("relock_after_bd", 8 * (SWAIT + 1) + LCNT + 4);
      check_val("bd_relock_offset", 32'(offset), 32'd0);

      // Delay 3: the word spans prev/cur with 5 bits from prev, so offset 5
      do_reset(3, 3);
      wait_lock("lock_d3", 8 * (SWAIT + 1) + LCNT + 4);
      check_val("offset_d3", 32'(offset), 32'd5);
      @(negedge clk40);
      check_val("dout_d3", 32'(dout), 32'(PAT));
      k0 = cyc + 2;
      send_word(k0,     8'h5A, 4);
      send_word(k0 + 1, 8'hC3, 4);
      drain("payload_d3");

      // align_start while locked: drop lock, relock at the same offset with no slips
      @(negedge clk40);
      align_start = 1'b1;
      @(negedge clk40);
      align_start = 1'b0;
      check_val("start_unlock", 32'(locked), 32'd0);
      check_val("start_offset", 32'(offset), 32'd5);
      slipped = 1'b0;
      for (int n = 0; n < 2 + LCNT + SWAIT && locked !== 1'b1; n++) begin
         @(negedge clk40);
         if (offset !== 3'd5) slipped = 1'b1;
      end
      check_val("start_relock", 32'(locked), 32'd1);
      check_val("start_no_slip", 32'(slipped), 32'd0);
`else
      // Fixed offset 0: locked straight after reset, dout tracks loopback data
      @(negedge clk40);
      check_val("locked_after_rst", 32'(locked), 32'd1);
      check_val("offset_fixed", 32'(offset), 32'd0);
      repeat (2) @(negedge clk40);
      check_val("dout_idle", 32'(dout), 32'(PAT));

      k0 = cyc + 2;
      send_word(k0,     8'h00, 3);
      send_word(k0 + 1, 8'hFF, 3);
      send_word(k0 + 2, 8'hA5, 3);
      send_word(k0 + 3, 8'h5A, 3);
      drain("payload");

      @(negedge clk40);
      rstn = 1'b0;
      @(negedge clk40);
      check_val("midrst_locked", 32'(locked), 32'd0);
      check_val("midrst_offset", 32'(offset), 32'd0);
      check_val("midrst_dout", 32'(dout), 32'd0);
      rstn = 1'b1;
      @(negedge clk40);
      check_val("midrst_relock", 32'(locked), 32'd1);

      repeat (3) @(negedge clk40);
      align_start = 1'b1;
      @(negedge clk40);
      align_start = 1'b0;
      check_val("start_ignored_locked", 32'(locked), 32'd1);
      check_val("start_ignored_offset", 32'(offset), 32'd0);
      k0 = cyc + 2;
      send_word(k0, 8'h3C, 3);
      drain("after_start");
`endif

      repeat (4) @(negedge clk40);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Absolute time guard so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
